sevenseg_scan: RTL and testbench
================================

Name: sevenseg_scan

Overview:
Downstream consumer of the binary-to-BCD converter's 16-bit packed BCD output (4 digits, digit 3 = thousands).
- Drives the board's 4-digit common-anode seven-segment display by time-multiplexing.
- Double-buffers the BCD value so a mid-conversion change never tears the display.
- Adds optional leading-zero blanking, per-digit decimal points and an anti-ghosting dead time between digits.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range is at least GAP+1.
GAP, 500, cycles at the start of each slot with all anodes off (dead time); legal range is at least 1.

Ports:
clk100Mhz  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
bcd  input  16  packed BCD; [15:12]=digit3 (MSD) ... [3:0]=digit0 (LSD)
update  input  1  single-cycle strobe: capture bcd and dp_en into shadow registers
dp_en  input  4  decimal point enable per digit, bit i = digit i
blank_lz  input  1  1 = blank leading zeros
an  output  4  anode enables, active-low, bit i = digit i
seg  output  7  {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
Clock and reset:
- One clock, clk100Mhz. Reset is synchronous and active-high on rst.
- All outputs are registered.

Reset values:
- an=4'b1111, seg=7'b1111111, dp=1.
- Shadow bcd=0, shadow dp_en=0.
- Digit index=0, slot counter=0, state=GAP.
- rst asserted mid-slot: reset values on the next edge, and the scan restarts from digit 0 in GAP.

Shadow load:
- On any cycle with update=1, shadow_bcd<=bcd and shadow_dp<=dp_en.
- The new value is used from the next slot start. The current slot keeps its registered seg/dp.
- update held high: the shadow registers reload every cycle, which is legal.

Slot counter:
- Counts 0..REFRESH_DIV-1, then wraps to 0.
- On wrap, the digit index increments mod 4 (order 0,1,2,3,0...).

FSM, two states:
- GAP: an=4'b1111. In the cycle the counter is 0, the seg/dp for the current digit are computed from the shadow registers and registered. Go to ACTIVE when counter==GAP-1.
- ACTIVE: an has only bit [index] low; seg/dp hold. Go to GAP on counter wrap.
- Latency: a digit is lit for exactly REFRESH_DIV-GAP cycles per slot, and dark for GAP cycles.

Decode (nibble to active-low seg):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Nibble >9 shows a dash, 0111111.

Leading-zero blanking (blank_lz=1):
- Digit i is blanked if it and every higher digit are 0.
- Digit 0 is never blanked, so value 0 shows "0".
- A blanked digit keeps its anode high for the whole slot (it still consumes its slot time), and dp is forced to 1.
- Exception: shadow_dp[i]=1 overrides blanking for that digit, and the digit shows a zero.
- A nibble >9 counts as non-zero.

Decimal point: dp = ~shadow_dp[index] for non-blanked digits.

Decomposition:
- Package sevenseg_pkg holds:
  - the SEG_0..SEG_9, SEG_DASH and SEG_OFF constants;
  - the state encoding (GAP, ACTIVE);
  - the default REFRESH_DIV and GAP values.
- One combinational sub-module, bcd_to_seg: 4-bit nibble in, 7-bit active-low segments out. It is instantiated once and fed by the index-selected shadow nibble.

Test Plan (REFRESH_DIV=8, GAP=2):
1. Reset: hold rst 3 cycles, then release. Expect an=1111, seg=1111111 and dp=1 during reset. The first ACTIVE state starts at cycle 2 after release, with an=1110.
2. bcd=16'h7850, update pulse, blank_lz=0. One full scan shows digit0 seg=1000000/an=1110, digit1 0010010/1101, digit2 0000000/1011, digit3 1111000/0111. Each digit is lit 6 cycles, then has a 2-cycle an=1111 gap.
3. bcd=16'h0012, blank_lz=1. Digits 3 and 2 keep an=1111 for their entire slots. Digit1 shows 1111001 and digit0 shows 0100100. With bcd=16'h0000, only digit0 lights, showing 1000000.
4. dp_en=4'b0100 with bcd=16'h0012, blank_lz=1. Digit2 lights with seg=1000000 and dp=0. Digit3 stays dark.
5. In the middle of digit1's ACTIVE slot, update with bcd=16'h9999. Digit1 keeps its old seg until the slot ends. The next slot, digit2, shows 0010000. Also apply bcd=16'h00A0 with blank_lz=0 and check that digit1 shows the dash, 0111111.
6. Assert rst during digit2's ACTIVE slot. On the next edge, an=1111, and the scan restarts at digit0 with the shadow cleared (blank_lz=1 gives "0" on digit0 only).

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants for the four-digit seven-segment scanner: segment
// patterns (active-low {g,f,e,d,c,b,a}), FSM encoding and default timing.
package sevenseg_pkg;

    localparam int REFRESH_DIV_DEFAULT = 100000;
    localparam int GAP_DEFAULT         = 500;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {
        ST_GAP    = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Nibble to active-low seven-segment pattern; non-decimal nibbles show a dash.
module bcd_to_seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup from BCD digit to segment pattern
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode display. The BCD value
// and decimal points are double-buffered; each digit slot starts with a dark
// dead time to stop ghosting, then lights one anode for the rest of the slot.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
    parameter int GAP         = GAP_DEFAULT
) (
    input  logic        clk100Mhz,
    input  logic        rst,
    input  logic [15:0] bcd,
    input  logic        update,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

    logic [15:0]      shadow_bcd;
    logic [3:0]       shadow_dp;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    state_t           state;
    state_t           state_next;
    logic             lit_q;
    logic             lit_use;
    logic             lead_zero;
    logic             blank_cur;
    logic             slot_start;
    logic [3:0]       nib;
    logic [6:0]       seg_dec;
    logic [3:0]       an_next;

    assign slot_start = (state == ST_GAP) && (cnt == '0);
    assign nib        = shadow_bcd[{idx, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .nibble (nib),
        .seg    (seg_dec)
    );

    // Shadow registers: reload on every update strobe, read only at slot start
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
        end else if (update) begin
            shadow_bcd <= bcd;
            shadow_dp  <= dp_en;
        end
    end

    // Slot counter and digit index; the index advances on each slot wrap
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Current digit is a leading zero when it and every higher digit are 0
    always_comb begin
        lead_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((i >= int'(idx)) && (shadow_bcd[4*i +: 4] != 4'd0)) begin
                lead_zero = 1'b0;
            end
        end
    end

    // A set decimal point keeps the digit visible even if it is a leading zero
    assign blank_cur = blank_lz && (idx != 2'd0) && !shadow_dp[idx] && lead_zero;

    // FSM state register
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            state <= ST_GAP;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: dark for GAP cycles, lit until the slot wraps
    always_comb begin
        state_next = state;
        case (state)
            ST_GAP:    if (cnt == GAP_LAST) state_next = ST_ACTIVE;
            ST_ACTIVE: if (cnt == CNT_MAX)  state_next = ST_GAP;
            default:   state_next = ST_GAP;
        endcase
    end

    // FSM output: anode pattern that will be registered on the next edge.
    // With GAP=1 the slot start and the lit transition share a cycle, so the
    // freshly computed blanking decision is used instead of the stored one.
    always_comb begin
        lit_use = slot_start ? !blank_cur : lit_q;
        an_next = 4'b1111;
        if ((state_next == ST_ACTIVE) && lit_use) begin
            an_next = ~(4'b0001 << idx);
        end
    end

    // Registered display outputs; seg/dp latch once per slot at its start
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            an    <= 4'b1111;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
            lit_q <= 1'b0;
        end else begin
            an <= an_next;
            if (slot_start) begin
                lit_q <= !blank_cur;
                seg   <= blank_cur ? SEG_OFF : seg_dec;
                dp    <= blank_cur ? 1'b1 : ~shadow_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan with REFRESH_DIV=8, GAP=2: a slot-level reference
// model checked every cycle, plus literal expectations at chosen cycles.
module tb_sevenseg_scan;

    localparam int R = 8;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd;
    logic        update;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int passed = 0;
    int total  = 0;

    sevenseg_scan #(.REFRESH_DIV(R), .GAP(G)) dut (
        .clk100Mhz (clk),
        .rst       (rst),
        .bcd       (bcd),
        .update    (update),
        .dp_en     (dp_en),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    // Reference model: edge k (counted from reset release) starts a slot when
    // k % R == 0; after edge k the slot position is (k+1) % R and the digit
    // shown is ((k+1)/R) % 4. A digit is lit once its position reaches G.
    int          mk   = -1;
    bit          m_ok = 1'b0;
    logic [15:0] m_bcd;
    logic [3:0]  m_dpv;
    logic        m_lit;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;

    function automatic logic [6:0] m_dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic m_visible(input logic [15:0] v, input logic [3:0] dpv,
                                       input logic blz, input int d);
        if (!blz || d == 0 || dpv[d]) return 1'b1;
        for (int j = d; j < 4; j++) if (v[4*j +: 4] != 4'd0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int d;
        int c;
        int dd;
        if (rst) begin
            mk = -1; m_bcd = '0; m_dpv = '0; m_lit = 1'b0;
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_ok = 1'b1;
        end else if (m_ok) begin
            mk++;
            if (mk % R == 0) begin
                d     = (mk / R) % 4;
                m_lit = m_visible(m_bcd, m_dpv, blank_lz, d);
                m_seg = m_lit ? m_dec(m_bcd[4*d +: 4]) : 7'h7F;
                m_dp  = m_lit ? ~m_dpv[d] : 1'b1;
            end
            if (update) begin
                m_bcd = bcd;
                m_dpv = dp_en;
            end
            c  = (mk + 1) % R;
            dd = ((mk + 1) / R) % 4;
            m_an = (c >= G && m_lit) ? ~(4'b0001 << dd) : 4'hF;
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s at k=%0d: an/seg/dp got %b_%b_%b want %b_%b_%b",
                     name, mk, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end else begin
            passed++;
        end
    endtask

    // Continuous compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_ok) chk("scan", {an, seg, dp}, {m_an, m_seg, m_dp});
    end

    task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic p);
        chk(name, {an, seg, dp}, {a, s, p});
    endtask

    task automatic at_edge(input int kk);
        int n = 0;
        while (mk != kk && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (mk != kk) begin
            total++;
            $display("FAIL at_edge: reached k=%0d want %0d", mk, kk);
        end
    endtask

    initial begin
        rst = 1'b1; update = 1'b0; bcd = '0; dp_en = '0; blank_lz = 1'b0;

        // 1: reset values, first lit cycle
        @(negedge clk);
        lit("reset", 4'b1111, 7'b1111111, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bcd = 16'h7850; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        lit("first_gap", 4'b1111, 7'b1000000, 1'b1);
        at_edge(1);  lit("first_active", 4'b1110, 7'b1000000, 1'b1);

        // 2: full scan of 7850
        at_edge(11); lit("d1_5", 4'b1101, 7'b0010010, 1'b1);
        at_edge(19); lit("d2_8", 4'b1011, 7'b0000000, 1'b1);
        at_edge(27); lit("d3_7", 4'b0111, 7'b1111000, 1'b1);
        at_edge(30); lit("d3_last_lit", 4'b0111, 7'b1111000, 1'b1);
        at_edge(31); lit("gap0", 4'b1111, 7'b1111000, 1'b1);
        at_edge(32); lit("gap1", 4'b1111, 7'b1000000, 1'b1);
        at_edge(33); lit("d0_0", 4'b1110, 7'b1000000, 1'b1);

        // 3: leading-zero blanking, update held two cycles
        at_edge(36);
        bcd = 16'h0012; blank_lz = 1'b1; update = 1'b1;
        @(negedge clk);
        @(negedge clk);
        update = 1'b0;
        at_edge(43); lit("lz_d1", 4'b1101, 7'b1111001, 1'b1);
        at_edge(51); lit("lz_d2_dark", 4'b1111, 7'b1111111, 1'b1);
        at_edge(59); lit("lz_d3_dark", 4'b1111, 7'b1111111, 1'b1);
        at_edge(67); lit("lz_d0", 4'b1110, 7'b0100100, 1'b1);
        at_edge(68);
        bcd = 16'h0000; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        at_edge(75); lit("zero_d1_dark", 4'b1111, 7'b1111111, 1'b1);
        at_edge(99); lit("zero_d0", 4'b1110, 7'b1000000, 1'b1);

        // 4: decimal point overrides blanking on digit 2
        at_edge(100);
        bcd = 16'h0012; dp_en = 4'b0100; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        at_edge(107); lit("dp_d1", 4'b1101, 7'b1111001, 1'b1);
        at_edge(115); lit("dp_d2", 4'b1011, 7'b1000000, 1'b0);
        at_edge(123); lit("dp_d3_dark", 4'b1111, 7'b1111111, 1'b1);

        // 5: mid-slot update does not tear; dash for non-decimal nibble
        at_edge(139);
        bcd = 16'h9999; dp_en = 4'b0000; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        at_edge(141); lit("no_tear_d1", 4'b1101, 7'b1111001, 1'b1);
        at_edge(147); lit("new_d2_9", 4'b1011, 7'b0010000, 1'b1);
        at_edge(150);
        bcd = 16'h00A0; blank_lz = 1'b0; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        at_edge(163); lit("a0_d0", 4'b1110, 7'b1000000, 1'b1);
        at_edge(171); lit("a0_d1_dash", 4'b1101, 7'b0111111, 1'b1);
        at_edge(179); lit("a0_d2", 4'b1011, 7'b1000000, 1'b1);

        // 6: reset during digit 2 active
        at_edge(211);
        rst = 1'b1; blank_lz = 1'b1;
        @(negedge clk);
        lit("mid_reset", 4'b1111, 7'b1111111, 1'b1);
        rst = 1'b0;
        at_edge(3);  lit("rst_d0", 4'b1110, 7'b1000000, 1'b1);
        at_edge(11); lit("rst_d1_dark", 4'b1111, 7'b1111111, 1'b1);
        at_edge(27); lit("rst_d3_dark", 4'b1111, 7'b1111111, 1'b1);
        at_edge(35); lit("rst_d0_again", 4'b1110, 7'b1000000, 1'b1);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
